// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared region codes, control bits, FSM states and sizing helper for the systolic engine
package npu_pkg;

    localparam logic [1:0] REG_W    = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_OUT  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 0;
    localparam int CTRL_DONE   = 1;
    localparam int CTRL_ERR    = 2;
    localparam int CTRL_NV_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } npu_state_e;

    function automatic int acc_w(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/npu_systolic_wb_pe.sv
// rtl/npu_systolic_wb_pe.sv - one signed weight-stationary MAC cell with registered right/down outputs
module npu_pe_mac #(
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [DW-1:0]    i_left,
    input  logic signed [ACC_W-1:0] i_up,
    input  logic signed [DW-1:0]    i_w,
    output logic signed [DW-1:0]    o_right,
    output logic signed [ACC_W-1:0] o_down
);

    logic signed [ACC_W-1:0] w_prod;
    logic signed [DW-1:0]    r_right;
    logic signed [ACC_W-1:0] r_down;

    // ACC_W holds the full product and the column sum, so truncating to ACC_W is exact
    assign w_prod = ACC_W'(i_left) * ACC_W'(i_w);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_right <= '0;
            r_down  <= '0;
        end else begin
            r_right <= i_left;
            r_down  <= i_up + w_prod;
        end
    end

    assign o_right = r_right;
    assign o_down  = r_down;

endmodule

// File: rtl/npu_systolic_wb.sv
// rtl/npu_systolic_wb.sv - Wishbone-attached weight-stationary NxN systolic matrix-vector engine
module npu_systolic_wb
    import npu_pkg::*;
#(
    parameter logic [19:0] BASE_ADR = 20'h30000,
    parameter int          N        = 3,
    parameter int          DW       = 8,
    parameter int          ROWS     = 16,
    parameter int          ACC_W    = acc_w(N, DW)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o
);

    localparam int NW    = N * N;
    localparam int NI    = ROWS * N;
    localparam int W_AW  = $clog2(NW);
    localparam int IN_AW = $clog2(NI);

    logic signed [DW-1:0]    r_w_mem   [NW];
    logic signed [DW-1:0]    r_in_mem  [NI];
    logic signed [ACC_W-1:0] r_out_mem [NI];

    npu_state_e r_state, w_state_next;
    logic [8:0] r_t, w_t_next, w_t_last;
    logic       r_err, w_err_next;
    logic [7:0] r_num_vec, w_num_vec_next;
    logic       r_start_pend;
    logic [7:0] r_start_nv;
    logic       r_ack;
    logic [31:0] r_dat, w_rd_data;

    logic       w_hit, w_acc, w_wr, w_locked, w_start_req;
    logic [1:0] w_region;
    logic [7:0] w_idx;
    logic       w_unused;

    logic signed [DW-1:0]    w_feed   [N];
    logic signed [DW-1:0]    w_right  [N][N];
    logic signed [ACC_W-1:0] w_down   [N][N];
    logic signed [ACC_W-1:0] w_bottom [N];
    logic [IN_AW-1:0]        w_cap_ix [N];
    logic [N-1:0]            w_cap_en;

    assign w_hit    = wb_stb_i & wb_cyc_i & (wb_adr_i[31:12] == BASE_ADR);
    assign w_acc    = w_hit & ~r_ack;
    assign w_wr     = w_acc & wb_we_i;
    assign w_region = wb_adr_i[11:10];
    assign w_idx    = wb_adr_i[9:2];
    // a START still waiting to be taken already freezes the operand memories
    assign w_locked = (r_state == ST_RUN) | r_start_pend;
    assign w_start_req = w_wr & (w_region == REG_CTRL) & (w_idx == 8'd0)
                       & wb_dat_i[CTRL_START] & ~w_locked;
    assign w_unused = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:16]};

    always_comb begin
        w_rd_data = '0;
        case (w_region)
            REG_W:   if (int'(w_idx) < NW) w_rd_data = 32'(r_w_mem[W_AW'(w_idx)]);
            REG_IN:  if (int'(w_idx) < NI) w_rd_data = 32'(r_in_mem[IN_AW'(w_idx)]);
            REG_OUT: if (int'(w_idx) < NI) w_rd_data = 32'(r_out_mem[IN_AW'(w_idx)]);
            default: if (w_idx == 8'd0)
                w_rd_data = {16'd0, r_num_vec, 5'd0, r_err,
                             r_state == ST_DONE, r_state == ST_RUN};
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack        <= 1'b0;
            r_dat        <= '0;
            r_start_pend <= 1'b0;
            r_start_nv   <= '0;
        end else begin
            r_ack        <= w_acc;
            r_dat        <= (w_acc & ~wb_we_i) ? w_rd_data : '0;
            r_start_pend <= w_start_req;
            if (w_start_req) r_start_nv <= wb_dat_i[CTRL_NV_LSB +: 8];
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;

    assign w_t_last = 9'(r_num_vec) + 9'(2 * N - 2);

    always_comb begin
        w_state_next   = r_state;
        w_t_next       = r_t;
        w_err_next     = r_err;
        w_num_vec_next = r_num_vec;
        case (r_state)
            ST_RUN: begin
                w_t_next = r_t + 9'd1;
                if (r_t == w_t_last) w_state_next = ST_DONE;
            end
            default: begin
                if (r_start_pend) begin
                    w_num_vec_next = r_start_nv;
                    if (int'(r_start_nv) > ROWS) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_err_next   = 1'b0;
                        w_t_next     = '0;
                        w_state_next = (r_start_nv == 8'd0) ? ST_DONE : ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_t       <= '0;
            r_err     <= 1'b0;
            r_num_vec <= '0;
        end else begin
            r_state   <= w_state_next;
            r_t       <= w_t_next;
            r_err     <= w_err_next;
            r_num_vec <= w_num_vec_next;
        end
    end

    // row r sees vector k at cycle t = k + r, giving the diagonal skew into the array
    for (genvar gr = 0; gr < N; gr++) begin : g_feed
        logic [8:0] w_k;
        logic       w_v;
        assign w_k = r_t - 9'(gr);
        assign w_v = (r_state == ST_RUN) && (r_t >= 9'(gr)) && (w_k < 9'(r_num_vec));
        assign w_feed[gr] = w_v ? r_in_mem[IN_AW'(int'(w_k) * N + gr)] : '0;
    end

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        logic w_unused_right;
        assign w_unused_right = ^w_right[gr][N-1];
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            logic signed [DW-1:0]    w_l;
            logic signed [ACC_W-1:0] w_u;
            if (gc == 0) begin : g_l0
                assign w_l = w_feed[gr];
            end else begin : g_ln
                assign w_l = w_right[gr][gc-1];
            end
            if (gr == 0) begin : g_u0
                assign w_u = '0;
            end else begin : g_un
                assign w_u = w_down[gr-1][gc];
            end
            npu_pe_mac #(.DW(DW), .ACC_W(ACC_W)) u_pe (
                .i_clk   (wb_clk_i),
                .i_rst   (wb_rst_i),
                .i_left  (w_l),
                .i_up    (w_u),
                .i_w     (r_w_mem[gr * N + gc]),
                .o_right (w_right[gr][gc]),
                .o_down  (w_down[gr][gc])
            );
        end
    end

    // column c finishes vector k at cycle t = k + N + c; this undoes the skew
    for (genvar gc = 0; gc < N; gc++) begin : g_cap
        logic [8:0] w_kc;
        assign w_bottom[gc] = w_down[N-1][gc];
        assign w_kc         = r_t - 9'(N + gc);
        assign w_cap_en[gc] = (r_state == ST_RUN) && (r_t >= 9'(N + gc))
                            && (w_kc < 9'(r_num_vec));
        assign w_cap_ix[gc] = IN_AW'(int'(w_kc) * N + gc);
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_wr && !w_locked) begin
            if (w_region == REG_W && int'(w_idx) < NW)
                r_w_mem[W_AW'(w_idx)] <= wb_dat_i[DW-1:0];
            if (w_region == REG_IN && int'(w_idx) < NI)
                r_in_mem[IN_AW'(w_idx)] <= wb_dat_i[DW-1:0];
        end
        for (int c = 0; c < N; c++) begin
            if (w_cap_en[c]) r_out_mem[w_cap_ix[c]] <= w_bottom[c];
        end
    end

endmodule
